// File: rtl/mod_n_timer_ctrl.sv
// mod_n_timer_ctrl
//   Sequencing controller around a mod-N up-counter. Takes a modulus and
//   repeat count through a valid/ready handshake. Runs the counter on start
//   and supports pause and abort. Pulses tc on every wrap. Pulses done after
//   the programmed number of wraps, or runs continuously when the repeat
//   count is 0.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_valid/cfg_ready config handshake (ready in IDLE and DONE only)
//   cfg_n               modulus, 0 encodes 2^WIDTH
//   cfg_reps            wraps before done, 0 = continuous
//   start, pause, abort run control (priority abort > start > pause)
//   count               current count value
//   tc                  registered pulse on the edge that wrapped N_eff-1 -> 0
//   rep_done            wraps completed this run (saturating)
//   busy                state is RUN or PAUSE
//   done                one-cycle pulse on entry to DONE
//   state               IDLE=0 RUN=1 PAUSE=2 DONE=3
module mod_n_timer_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEF_N = 10,
   parameter int unsigned REP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_n,
   input  logic [REP_W-1:0] cfg_reps,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [REP_W-1:0] rep_done,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   // Modulus is held one bit wider so that 2^WIDTH is representable
   localparam int unsigned    NW      = WIDTH + 1;
   localparam logic [NW-1:0]  N_MAX   = NW'(2**WIDTH);
   localparam logic [NW-1:0]  N_RST   = NW'(DEF_N);
   localparam logic [REP_W-1:0] REP_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           st_q, st_d;
   logic [WIDTH-1:0] count_d;
   logic [REP_W-1:0] rep_d;
   logic             tc_d, done_d;
   logic [NW-1:0]    n_eff_q;
   logic [REP_W-1:0] reps_q;
   logic             idle_or_done, active, cfg_take, at_top, last_wrap;
   logic [REP_W:0]   rep_inc;

   assign idle_or_done = (st_q == S_IDLE) || (st_q == S_DONE);
   assign active       = (st_q == S_RUN)  || (st_q == S_PAUSE);
   assign cfg_ready    = idle_or_done;
   assign busy         = active;
   assign state        = st_q;
   assign cfg_take     = cfg_valid & idle_or_done;

   // Terminal compare done at WIDTH+1 bits so N_eff = 2^WIDTH is not truncated
   assign at_top    = ({1'b0, count} == (n_eff_q - NW'(1)));
   assign rep_inc   = {1'b0, rep_done} + (REP_W+1)'(1);
   assign last_wrap = at_top && (reps_q != '0) && (rep_inc == {1'b0, reps_q});

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= S_IDLE;
      end else begin
         st_q <= st_d;
      end
   end

   // Next-state decode
   always_comb begin
      st_d = st_q;
      if (abort) begin
         st_d = S_IDLE;
      end else if (idle_or_done) begin
         if (start) begin
            st_d = S_RUN;
         end
      end else if (pause) begin
         st_d = S_PAUSE;
      end else if (last_wrap) begin
         st_d = S_DONE;
      end else begin
         st_d = S_RUN;
      end
   end

   // Counter, wrap counter and pulse next values
   always_comb begin
      count_d = count;
      rep_d   = rep_done;
      tc_d    = 1'b0;
      done_d  = 1'b0;
      if (abort) begin
         count_d = '0;
      end else if (idle_or_done) begin
         if (start) begin
            count_d = '0;
            rep_d   = '0;
         end
      end else if (!pause) begin
         if (at_top) begin
            count_d = '0;
            tc_d    = 1'b1;
            done_d  = last_wrap;
            if (rep_done != REP_MAX) begin
               rep_d = rep_done + REP_W'(1);
            end
         end else begin
            count_d = count + WIDTH'(1);
         end
      end
   end

   // Datapath and stored configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         tc       <= 1'b0;
         done     <= 1'b0;
         rep_done <= '0;
         n_eff_q  <= N_RST;
         reps_q   <= '0;
      end else begin
         count    <= count_d;
         tc       <= tc_d;
         done     <= done_d;
         rep_done <= rep_d;
         if (cfg_take) begin
            n_eff_q <= (cfg_n == '0) ? N_MAX : {1'b0, cfg_n};
            reps_q  <= cfg_reps;
         end
      end
   end

endmodule

// File: tb/tb_mod_n_timer_ctrl.sv
// Scoreboard bench for mod_n_timer_ctrl: the stimulus process predicts each
// edge with a behavioural model and queues the result; the monitor checks
// the DUT outputs just after every rising edge.
module tb_mod_n_timer_ctrl;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEF_N = 10;
   localparam int unsigned REP_W = 8;
   localparam int          REP_SAT = (1 << REP_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_n;
   logic [REP_W-1:0] cfg_reps;
   logic             start, pause, abort;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic [REP_W-1:0] rep_done;
   logic             busy, done;
   logic [1:0]       state;

   mod_n_timer_ctrl #(.WIDTH(WIDTH), .DEF_N(DEF_N), .REP_W(REP_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_n(cfg_n), .cfg_reps(cfg_reps),
      .start(start), .pause(pause), .abort(abort),
      .count(count), .tc(tc), .rep_done(rep_done),
      .busy(busy), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int count;
      int tc;
      int rep;
      int busy;
      int done;
      int state;
      int ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: plain integers, state names as 0..3
   int m_state, m_count, m_n, m_reps, m_rep, m_tc, m_done;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_count = 0; m_n = DEF_N; m_reps = 0;
      m_rep = 0; m_tc = 0; m_done = 0;
   endtask

   task automatic model_step(input bit r, input bit v, input int n, input int reps,
                             input bit st, input bit pa, input bit ab);
      bit idle_like;
      int new_n, new_reps;
      exp_t e;
      if (!r) begin
         model_reset();
      end else begin
         idle_like = (m_state == 0) || (m_state == 3);
         new_n = m_n;
         new_reps = m_reps;
         if (v && idle_like) begin
            new_n = (n == 0) ? (1 << WIDTH) : n;
            new_reps = reps;
         end
         m_tc = 0;
         m_done = 0;
         if (ab) begin
            m_state = 0;
            m_count = 0;
         end else if (idle_like) begin
            if (st) begin
               m_state = 1; m_count = 0; m_rep = 0;
            end
         end else if (pa) begin
            m_state = 2;
         end else begin
            m_state = 1;
            if ((m_count + 1) % m_n == 0) begin
               m_count = 0;
               m_tc = 1;
               if (m_reps != 0 && m_rep + 1 == m_reps) begin
                  m_state = 3;
                  m_done = 1;
               end
               if (m_rep < REP_SAT) m_rep = m_rep + 1;
            end else begin
               m_count = m_count + 1;
            end
         end
         m_n = new_n;
         m_reps = new_reps;
      end
      e.count = m_count; e.tc = m_tc; e.rep = m_rep; e.done = m_done;
      e.state = m_state;
      e.busy  = (m_state == 1 || m_state == 2) ? 1 : 0;
      e.ready = (m_state == 0 || m_state == 3) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   // Drive one edge's inputs and queue its predicted outcome
   task automatic cycle(input bit r, input bit v, input int n, input int reps,
                        input bit st, input bit pa, input bit ab);
      @(negedge clk);
      rst_n = r; cfg_valid = v; cfg_n = WIDTH'(n); cfg_reps = REP_W'(reps);
      start = st; pause = pa; abort = ab;
      model_step(r, v, n, reps, st, pa, ab);
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) cycle(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, int'(count), 0);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_ready"}, int'(cfg_ready), 1);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_tc"},    int'(tc), 0);
      check({tag, "_done"},  int'(done), 0);
      check({tag, "_rep"},   int'(rep_done), 0);
   endtask

   // Monitor: every edge presents a new output set
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count",     int'(count),     e.count);
            check("tc",        int'(tc),        e.tc);
            check("rep_done",  int'(rep_done),  e.rep);
            check("busy",      int'(busy),      e.busy);
            check("done",      int'(done),      e.done);
            check("state",     int'(state),     e.state);
            check("cfg_ready", int'(cfg_ready), e.ready);
         end
      end
   end

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_reps = '0;
      start = 1'b0; pause = 1'b0; abort = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("por");
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);

      // 1: async reset mid-run at count 4, then default modulus again
      cycle(1, 1, 6, 0, 1, 0, 0);
      idle_cycles(4);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);

      // 2: default modulus, continuous
      cycle(1, 0, 0, 0, 1, 0, 0);
      idle_cycles(35);

      // 3: N=3, two wraps then done (config and start on the same edge)
      cycle(1, 1, 3, 2, 1, 0, 0);
      idle_cycles(8);

      // 4: N=5 continuous, pause held three edges at count 2
      cycle(1, 1, 5, 0, 1, 0, 0);
      idle_cycles(2);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 0);
      idle_cycles(4);

      // 5: N=2^WIDTH, then N=1 continuous, then N=1 with three reps
      cycle(1, 0, 0, 0, 0, 0, 1);
      cycle(1, 1, 0, 0, 1, 0, 0);
      idle_cycles(20);
      cycle(1, 0, 0, 0, 0, 0, 1);
      cycle(1, 1, 1, 0, 1, 0, 0);
      idle_cycles(5);
      cycle(1, 0, 0, 0, 0, 0, 1);
      cycle(1, 1, 1, 3, 1, 0, 0);
      idle_cycles(4);

      // 6: offer while busy is held, abort+start together, offer then taken
      cycle(1, 1, 4, 0, 1, 0, 0);
      idle_cycles(3);
      cycle(1, 1, 7, 0, 0, 0, 0);
      cycle(1, 1, 7, 0, 0, 0, 0);
      cycle(1, 1, 7, 0, 1, 0, 1);
      cycle(1, 1, 7, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1, 0, 0);
      idle_cycles(10);

      // Randomised phase
      for (int i = 0; i < 3000; i++) begin
         bit r, v, st, pa, ab;
         int n, reps;
         r    = ($urandom_range(0, 199) != 0);
         v    = ($urandom_range(0, 9) == 0);
         n    = $urandom_range(0, 15);
         reps = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
         st   = ($urandom_range(0, 19) == 0);
         pa   = ($urandom_range(0, 4) == 0);
         ab   = ($urandom_range(0, 49) == 0);
         cycle(r, v, n, reps, st, pa, ab);
      end
      idle_cycles(3);

      @(posedge clk);
      #2;
      check("queue_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
